// File: rtl/seg_scan_reader_if.sv
// Seven-segment scan bus as seen by a display reader: raw segment/enable
// lines in, decoded frame results out.
interface seg_scan_reader_if #(
  parameter int unsigned NDIG = 4
);
  logic [6:0]        seg_i;
  logic [NDIG-1:0]   an_i;
  logic [4*NDIG-1:0] value_o;
  logic              frame_valid_o;
  logic              err_o;
  logic              busy_o;

  modport master (
    output seg_i, an_i,
    input  value_o, frame_valid_o, err_o, busy_o
  );

  modport slave (
    input  seg_i, an_i,
    output value_o, frame_valid_o, err_o, busy_o
  );
endinterface

// File: rtl/seg_scan_reader.sv
// Samples a multiplexed seven-segment display, decodes each stable digit back
// to a hex nibble and publishes a full frame once every digit has been seen.
module seg_scan_reader #(
  parameter int unsigned NDIG       = 4,
  parameter int unsigned STABLE_CYC = 4
) (
  input logic                clk,
  input logic                rst_n,
  seg_scan_reader_if.slave   bus
);

  localparam logic [NDIG-1:0] ONE = NDIG'(1);

  logic [6:0]            s_seg, p_seg;
  logic [NDIG-1:0]       s_an, p_an;
  logic [7:0]            cnt;
  logic [NDIG-1:0]       mask, mask_base;
  logic [NDIG-1:0][3:0]  nib;
  logic [NDIG-1:0]       inv;
  logic [NDIG-1:0]       sel;
  logic                  sel_valid, same, capture, frame_done;
  logic [4:0]            dec;
  logic [4*NDIG-1:0]     value_r;
  logic                  fv_r, err_r;

  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b1111110: decode = 5'h00;
      7'b0110000: decode = 5'h01;
      7'b1101101: decode = 5'h02;
      7'b1111001: decode = 5'h03;
      7'b0110011: decode = 5'h04;
      7'b1011011: decode = 5'h05;
      7'b1011111: decode = 5'h06;
      7'b1110000: decode = 5'h07;
      7'b1111111: decode = 5'h08;
      7'b1111011: decode = 5'h09;
      7'b1110111: decode = 5'h0A;
      7'b0011111: decode = 5'h0B;
      7'b1001110: decode = 5'h0C;
      7'b0111101: decode = 5'h0D;
      7'b1001111: decode = 5'h0E;
      7'b1000111: decode = 5'h0F;
      default:    decode = 5'h10;
    endcase
  endfunction

  always_comb begin
    sel        = ~s_an;
    // Exactly one enable low: non-zero and a power of two.
    sel_valid  = (sel != '0) && ((sel & (sel - ONE)) == '0);
    same       = (s_an == p_an) && (s_seg == p_seg);
    capture    = sel_valid && same && (cnt == 8'(STABLE_CYC - 1));
    dec        = decode(s_seg);
    frame_done = &mask;
    // A capture on the completion edge starts the next frame's mask.
    mask_base  = frame_done ? '0 : mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_seg   <= '0;
      p_seg   <= '0;
      s_an    <= '1;
      p_an    <= '1;
      cnt     <= '0;
      mask    <= '0;
      nib     <= '0;
      inv     <= '0;
      value_r <= '0;
      fv_r    <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      s_seg <= bus.seg_i;
      s_an  <= bus.an_i;
      p_seg <= s_seg;
      p_an  <= s_an;

      if (!sel_valid)
        cnt <= '0;
      else if (!same)
        cnt <= 8'd1;
      else if (cnt != 8'(STABLE_CYC))
        cnt <= cnt + 8'd1;

      fv_r <= 1'b0;
      if (frame_done) begin
        value_r <= nib;
        err_r   <= |inv;
        fv_r    <= 1'b1;
      end

      mask <= mask_base | (capture ? sel : '0);
      for (int unsigned k = 0; k < NDIG; k++) begin
        if (capture && sel[k]) begin
          nib[k] <= dec[3:0];
          inv[k] <= dec[4];
        end
      end
    end
  end

  assign bus.value_o       = value_r;
  assign bus.frame_valid_o = fv_r;
  assign bus.err_o         = err_r;
  assign bus.busy_o        = |mask;

endmodule
